// File: rtl/button_debounce_if.sv
// Button conditioner bus.
// Groups the per-button signals between the board pins and the debouncer.
// Signal names keep the debouncer's port names so existing wiring maps directly.
//   btn_i   raw asynchronous button pins               (master -> slave)
//   clear_i per-bit clear of the sticky press flag     (master -> slave)
//   btn_o   debounced level, 1 = pressed               (slave -> master)
//   rise_o  1-cycle pulse when btn_o goes 0->1         (slave -> master)
//   fall_o  1-cycle pulse when btn_o goes 1->0         (slave -> master)
//   press_o sticky press flag, set by rise             (slave -> master)
interface button_debounce_if #(
  parameter int unsigned NumBtn = 3
);
  logic [NumBtn-1:0] btn_i;
  logic [NumBtn-1:0] clear_i;
  logic [NumBtn-1:0] btn_o;
  logic [NumBtn-1:0] rise_o;
  logic [NumBtn-1:0] fall_o;
  logic [NumBtn-1:0] press_o;

  modport master (
    output btn_i,
    output clear_i,
    input  btn_o,
    input  rise_o,
    input  fall_o,
    input  press_o
  );

  modport slave (
    input  btn_i,
    input  clear_i,
    output btn_o,
    output rise_o,
    output fall_o,
    output press_o
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner.
// Per bit: 2-flop synchronizer, stability-count debouncer, registered edge
// detector and a sticky press flag that software clears with clear_i.
// Ports:
//   clk_i   system clock (SoC domain)
//   rst_ni  synchronous active-low reset
//   bus     button_debounce_if slave: btn_i/clear_i in, btn_o/rise_o/fall_o/press_o out
// Parameters:
//   NumBtn       number of independent buttons (>=1)
//   StableCycles cycles a new level must hold before it is accepted (>=1)
//   InvertIn     1 = pins are active-low; inverted after synchronization
module button_debounce #(
  parameter int unsigned NumBtn       = 3,
  parameter int unsigned StableCycles = 60000,
  parameter bit          InvertIn     = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  button_debounce_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(StableCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(StableCycles - 1);
  localparam logic [NumBtn-1:0] InvMask = {NumBtn{InvertIn}};

  // Synchronizer: s1 -> s2 with nothing in between.
  logic [NumBtn-1:0] s1_q, s2_q;
  logic [NumBtn-1:0] lvl;

  logic [CntWidth-1:0] cnt_q [NumBtn];
  logic [CntWidth-1:0] cnt_d [NumBtn];

  logic [NumBtn-1:0] btn_q, btn_d;
  logic [NumBtn-1:0] rise_q, rise_d;
  logic [NumBtn-1:0] fall_q, fall_d;
  logic [NumBtn-1:0] press_q, press_d;

  always_comb begin
    lvl   = s2_q ^ InvMask;
    btn_d = btn_q;
    cnt_d = '{default: '0};
    for (int unsigned i = 0; i < NumBtn; i++) begin
      // Any sample matching the accepted level leaves cnt_d at 0, which is
      // what restarts the count after a glitch.
      if (lvl[i] != btn_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          btn_d[i] = lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
    end
    rise_d  = btn_d & ~btn_q;
    fall_d  = ~btn_d & btn_q;
    // Set dominates clear when both land on the same edge.
    press_d = (press_q & ~bus.clear_i) | rise_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= InvMask;
      s2_q    <= InvMask;
      cnt_q   <= '{default: '0};
      btn_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
    end else begin
      s1_q    <= bus.btn_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  assign bus.btn_o   = btn_q;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.press_o = press_q;

  // A bit can only change in one direction per edge.
  a_no_rise_and_fall : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rise_q & fall_q) == '0);

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  logic clk;
  logic rst_n;

  button_debounce_if #(.NumBtn(3)) bus1 ();
  button_debounce_if #(.NumBtn(3)) bus2 ();

  button_debounce #(
    .NumBtn(3),
    .StableCycles(4),
    .InvertIn(1'b0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus1)
  );

  button_debounce #(
    .NumBtn(3),
    .StableCycles(4),
    .InvertIn(1'b1)
  ) dut_inv (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic [2:0] btn;
    logic [2:0] clr;
    logic [2:0] e_btn;
    logic [2:0] e_rise;
    logic [2:0] e_fall;
    logic [2:0] e_press;
  } vec_t;

  vec_t tbl [31];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] eb, input logic [2:0] er,
                         input logic [2:0] ef, input logic [2:0] ep);
    chk({name, ".btn"},   bus1.btn_o,   eb);
    chk({name, ".rise"},  bus1.rise_o,  er);
    chk({name, ".fall"},  bus1.fall_o,  ef);
    chk({name, ".press"}, bus1.press_o, ep);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst, btn, clr, exp btn, rise, fall, press
    tbl[0]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    // bit0 steps high at edge 4 -> accepted at edge 9
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{1'b1, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000, 3'b001};
    tbl[10] = '{1'b1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
    tbl[11] = '{1'b1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
    // bit1: high 3, low 1, high from 16 on -> single rise at edge 21
    for (int i = 12; i <= 20; i++)
      tbl[i] = '{1'b1, 3'b011, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001};
    tbl[15].btn = 3'b001;
    tbl[21] = '{1'b1, 3'b011, 3'b000, 3'b011, 3'b010, 3'b000, 3'b011};
    tbl[22] = '{1'b1, 3'b011, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011};
    // bit0 released at edge 23 -> fall at edge 28, press stays until cleared
    for (int i = 23; i <= 27; i++)
      tbl[i] = '{1'b1, 3'b010, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011};
    tbl[28] = '{1'b1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b001, 3'b011};
    tbl[29] = '{1'b1, 3'b010, 3'b001, 3'b010, 3'b000, 3'b000, 3'b010};
    tbl[30] = '{1'b1, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010};

    rst_n        = 1'b0;
    bus1.btn_i   = 3'b000;
    bus1.clear_i = 3'b000;
    bus2.btn_i   = 3'b111;
    bus2.clear_i = 3'b000;
    #2;

    for (int i = 0; i < 31; i++) begin
      rst_n        = tbl[i].rst_n;
      bus1.btn_i   = tbl[i].btn;
      bus1.clear_i = tbl[i].clr;
      tick(1);
      chk_all($sformatf("vec%0d", i), tbl[i].e_btn, tbl[i].e_rise,
              tbl[i].e_fall, tbl[i].e_press);
    end

    // Inverted instance idles at 1 on the pins and must read released.
    chk("inv_idle.btn",   bus2.btn_o,   3'b000);
    chk("inv_idle.press", bus2.press_o, 3'b000);

    // Bit2 press, release, then re-press with clear on the rise edge.
    bus1.btn_i = 3'b110;
    tick(5);
    chk_all("b2_pre", 3'b010, 3'b000, 3'b000, 3'b010);
    tick(1);
    chk_all("b2_rise", 3'b110, 3'b100, 3'b000, 3'b110);
    tick(1);
    chk_all("b2_hold", 3'b110, 3'b000, 3'b000, 3'b110);
    bus1.btn_i = 3'b010;
    tick(6);
    chk_all("b2_fall", 3'b010, 3'b000, 3'b100, 3'b110);
    bus1.btn_i = 3'b110;
    tick(5);
    chk_all("b2_repre", 3'b010, 3'b000, 3'b000, 3'b110);
    bus1.clear_i = 3'b100;
    tick(1);
    chk_all("b2_set_wins", 3'b110, 3'b100, 3'b000, 3'b110);
    tick(1);
    chk_all("b2_clear", 3'b110, 3'b000, 3'b000, 3'b010);
    bus1.clear_i = 3'b010;
    tick(1);
    chk("b1_clear.press", bus1.press_o, 3'b000);
    bus1.clear_i = 3'b000;
    tick(1);
    chk("idle.press", bus1.press_o, 3'b000);

    // Reset while levels are high: no fall pulse on the reset edge.
    rst_n      = 1'b0;
    bus1.btn_i = 3'b000;
    tick(1);
    chk_all("rst_edge", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);

    // Reset mid-count discards the partial count.
    rst_n      = 1'b1;
    bus1.btn_i = 3'b111;
    tick(4);
    chk_all("midcnt", 3'b000, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b0;
    tick(1);
    chk_all("midcnt_rst", 3'b000, 3'b000, 3'b000, 3'b000);
    rst_n = 1'b1;
    tick(5);
    chk_all("after_rst_early", 3'b000, 3'b000, 3'b000, 3'b000);
    tick(1);
    chk_all("after_rst_accept", 3'b111, 3'b111, 3'b000, 3'b111);
    tick(1);
    chk("after_rst_pulse_end.rise", bus1.rise_o, 3'b000);

    // Active-low pins: pulling bit0 low is a press.
    bus2.btn_i = 3'b110;
    tick(5);
    chk("inv_early.btn",  bus2.btn_o,  3'b000);
    chk("inv_early.rise", bus2.rise_o, 3'b000);
    tick(1);
    chk("inv_rise.btn",   bus2.btn_o,   3'b001);
    chk("inv_rise.rise",  bus2.rise_o,  3'b001);
    chk("inv_rise.press", bus2.press_o, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
